// File: rtl/seq_divmod.sv
// Sequential unsigned divider: restoring division, one quotient bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module seq_divmod #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  // Shifted partial remainder is one bit wider than the operands so the
  // compare against the divisor cannot overflow.
  logic [WIDTH:0]   shifted;
  logic             fits;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    shifted = {rem_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = a;
          dvs_d = b;
          if (b == '0) begin
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // The difference is below the divisor, so the low WIDTH bits suffice.
        rem_d = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == CALC);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed self-checking bench for seq_divmod (WIDTH = 16).
module tb_seq_divmod;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divmod #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),    32'd1);
    check({tag, ".out_valid"}, 32'(out_valid),   32'd0);
    check({tag, ".busy"},      32'(busy),        32'd0);
    check({tag, ".quotient"},  32'(quotient),    32'd0);
    check({tag, ".remainder"}, 32'(remainder),   32'd0);
    check({tag, ".dbz"},       32'(div_by_zero), 32'd0);
  endtask

  // Present one operation, wait for the result, check it, then complete the handshake.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, ".ready_wait"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'h0003;
    check({tag, ".busy"}, 32'(busy), (vb == '0) ? 32'd0 : 32'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, ".latency"},   32'(lat),         (vb == '0) ? 32'd0 : 32'(W));
    check({tag, ".quotient"},  32'(quotient),    32'(eq));
    check({tag, ".remainder"}, 32'(remainder),   32'(er));
    check({tag, ".dbz"},       32'(div_by_zero), 32'(edbz));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2,   dbz: 1'b0};
    vecs[1] = '{a: 16'd5,     b: 16'd0,     q: 16'hFFFF,  r: 16'd5,   dbz: 1'b1};
    vecs[2] = '{a: 16'd3,     b: 16'd9,     q: 16'd0,     r: 16'd3,   dbz: 1'b0};
    vecs[3] = '{a: 16'hFFFF,  b: 16'd1,     q: 16'hFFFF,  r: 16'd0,   dbz: 1'b0};
    vecs[4] = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,     r: 16'd0,   dbz: 1'b0};
    vecs[5] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,   dbz: 1'b0};
    vecs[6] = '{a: 16'd1000,  b: 16'd33,    q: 16'd30,    r: 16'd10,  dbz: 1'b0};
    vecs[7] = '{a: 16'hFFFF,  b: 16'd256,   q: 16'd255,   r: 16'd255, dbz: 1'b0};
    vecs[8] = '{a: 16'd7,     b: 16'd7,     q: 16'd1,     r: 16'd0,   dbz: 1'b0};
    vecs[9] = '{a: 16'd0,     b: 16'd0,     q: 16'hFFFF,  r: 16'd0,   dbz: 1'b1};

    #3;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // Backpressure: result must hold while out_ready stays low; in_valid ignored.
    in_valid = 1'b1; a = 16'd50; b = 16'd6;
    tick();
    in_valid = 1'b0;
    wait_valid("bp");
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      a = 16'd1; b = 16'd1;
      tick();
      check("bp.hold_q",         32'(quotient),  32'd8);
      check("bp.hold_r",         32'(remainder), 32'd2);
      check("bp.hold_in_ready",  32'(in_ready),  32'd0);
      check("bp.hold_out_valid", 32'(out_valid), 32'd1);
    end

    // Handshake with in_valid high: no same-cycle restart; accepted one cycle later.
    in_valid = 1'b1; a = 16'd9; b = 16'd4;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b.idle_after_hs", 32'(in_ready), 32'd1);
    check("b2b.not_busy",      32'(busy),     32'd0);
    tick();
    check("b2b.accepted", 32'(busy), 32'd1);
    a = 16'd200; b = 16'd3;
    tick();
    a = 16'd77; b = 16'd0;
    wait_valid("b2b1");
    check("b2b1.q", 32'(quotient),  32'd2);
    check("b2b1.r", 32'(remainder), 32'd1);
    a = 16'd20; b = 16'd3;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b2.idle", 32'(in_ready), 32'd1);
    tick();
    check("b2b2.accepted", 32'(busy), 32'd1);
    a = 16'd1; b = 16'd1;
    wait_valid("b2b2");
    check("b2b2.q", 32'(quotient),  32'd6);
    check("b2b2.r", 32'(remainder), 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of CALC: outputs clear without a clock edge.
    in_valid = 1'b1; a = 16'd1000; b = 16'd33;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("mid.busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    #2;
    rst_n = 1'b1;
    run_op("after_reset", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

    // Reset while holding a result in DONE.
    in_valid = 1'b1; a = 16'd5; b = 16'd0;
    tick();
    in_valid = 1'b0;
    check("done.valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("donereset");
    #2;
    rst_n = 1'b1;
    tick();
    check("done.no_result", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
